// File: rtl/mul_acc_stage.sv
// Sums each group of N_TERMS valid products from the multiplier into one dot-product result.
// Latency: sum_vld rises on the edge that samples the last product of a group.
// Backpressure: input is never stalled; a result that finds the output register full is dropped and ovr_err is set.
module mul_acc_stage #(
   parameter int P_W     = 8,
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 10,
   parameter int CNT_W   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vld_in,
   input  logic [P_W-1:0]   p,
   input  logic             clr,
   output logic [ACC_W-1:0] sum,
   output logic             sum_vld,
   input  logic             sum_rdy,
   output logic             busy,
   output logic             ovr_err
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;
   logic [ACC_W-1:0] t;
   logic             take;
   logic             complete;
   logic             out_free;

   // Group arithmetic: next partial sum, counter advance and group-completion detect.
   always_comb begin
      cnt_nxt  = cnt;
      acc_nxt  = acc;
      take     = vld_in && !clr;
      // The first term of a group ignores any stale accumulator contents.
      t        = ((cnt == '0) ? '0 : acc) + ACC_W'(p);
      complete = take && (cnt == LAST_CNT);
      // The register can take a new result if empty or being drained this cycle.
      out_free = !sum_vld || sum_rdy;
      if (clr) begin
         cnt_nxt = '0;
         acc_nxt = '0;
      end else if (take) begin
         if (complete) begin
            cnt_nxt = '0;
            acc_nxt = '0;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
            acc_nxt = t;
         end
      end
   end

   // Group state; busy is registered from the next counter value so it tracks cnt != 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         acc  <= '0;
         busy <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         acc  <= acc_nxt;
         busy <= (cnt_nxt != '0);
      end
   end

   // Output register: load a completed sum when free, otherwise clear valid on a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum     <= '0;
         sum_vld <= 1'b0;
      end else if (complete && out_free) begin
         sum     <= t;
         sum_vld <= 1'b1;
      end else if (sum_vld && sum_rdy) begin
         sum_vld <= 1'b0;
      end
   end

   // Sticky overrun flag: set on a dropped group, cleared only by clr or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_err <= 1'b0;
      end else if (clr) begin
         ovr_err <= 1'b0;
      end else if (complete && !out_free) begin
         ovr_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mul_acc_stage.sv
module tb_mul_acc_stage;

   localparam int P_W     = 8;
   localparam int N_TERMS = 4;
   localparam int ACC_W   = 10;
   localparam int CNT_W   = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             vld_in;
   logic [P_W-1:0]   p;
   logic             clr;
   logic [ACC_W-1:0] sum;
   logic             sum_vld;
   logic             sum_rdy;
   logic             busy;
   logic             ovr_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the open group is a list of products; the output is a single slot.
   int grp[$];
   int m_sum;
   bit m_vld;
   bit m_ovr;

   always #5 clk = ~clk;

   mul_acc_stage #(
      .P_W(P_W), .N_TERMS(N_TERMS), .ACC_W(ACC_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .p(p), .clr(clr),
      .sum(sum), .sum_vld(sum_vld), .sum_rdy(sum_rdy), .busy(busy), .ovr_err(ovr_err)
   );

   function automatic int grp_total();
      int s = 0;
      foreach (grp[i]) s += grp[i];
      return s;
   endfunction

   task automatic model_reset();
      grp.delete();
      m_sum = 0;
      m_vld = 0;
      m_ovr = 0;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, return 1 time unit later.
   task automatic step(input bit v, input int pv, input bit c, input bit r);
      bit free;
      bit complete;
      int total;
      vld_in  = v;
      p       = pv[P_W-1:0];
      clr     = c;
      sum_rdy = r;
      @(posedge clk);
      free     = !m_vld || r;
      complete = 0;
      total    = 0;
      if (c) begin
         grp.delete();
         m_ovr = 0;
      end else if (v) begin
         grp.push_back(pv);
         if (grp.size() == N_TERMS) begin
            complete = 1;
            total    = grp_total();
            grp.delete();
         end
      end
      if (complete && free) begin
         m_sum = total;
         m_vld = 1;
      end else begin
         if (complete) m_ovr = 1;
         if (m_vld && r) m_vld = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0; vld_in = 0; p = '0; clr = 0; sum_rdy = 0;
      model_reset();
      #3;
      n_checks++;
      if ({sum, sum_vld, busy, ovr_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: sum=%0d vld=%b busy=%b ovr=%b, required all 0", sum, sum_vld, busy, ovr_err);
      end
      @(negedge clk); rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int beats[4] = '{6, 78, 255, 1};
      for (int i = 0; i < 4; i++) begin
         step(1, beats[i], 0, 1);
         n_checks++;
         if (busy !== (i < 3)) begin
            n_fail++;
            $display("FAIL basic_busy beat %0d: got %b, required %b", i + 1, busy, (i < 3));
         end
         n_checks++;
         if (sum_vld !== (i == 3)) begin
            n_fail++;
            $display("FAIL basic_vld beat %0d: got %b, required %b", i + 1, sum_vld, (i == 3));
         end
      end
      n_checks++;
      if (sum !== 10'd340 || sum !== m_sum[ACC_W-1:0]) begin
         n_fail++;
         $display("FAIL basic_sum: got %0d, required 340", sum);
      end
      step(0, 0, 0, 1);
      n_checks++;
      if (sum_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_drain: sum_vld=%b, required 0", sum_vld);
      end
   endtask

   task automatic test_max();
      for (int i = 0; i < 4; i++) begin
         step(1, 225, 0, 1);
         for (int g = 0; g < 2 && i < 3; g++) begin
            step(0, 0, 0, 1);
            n_checks++;
            if (busy !== 1'b1 || sum_vld !== 1'b0) begin
               n_fail++;
               $display("FAIL max_gap beat %0d: busy=%b vld=%b, required 1/0", i + 1, busy, sum_vld);
            end
         end
      end
      n_checks++;
      if (sum !== 10'd900 || sum_vld !== 1'b1 || ovr_err !== 1'b0) begin
         n_fail++;
         $display("FAIL max_sum: sum=%0d vld=%b ovr=%b, required 900/1/0", sum, sum_vld, ovr_err);
      end
      step(0, 0, 0, 1);
   endtask

   task automatic test_drain_load();
      for (int i = 1; i <= 4; i++) step(1, i, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 10, 0, 0);
      n_checks++;
      if (sum !== 10'd10 || sum_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL dl_hold: sum=%0d vld=%b, required 10/1", sum, sum_vld);
      end
      step(1, 10, 0, 1);
      n_checks++;
      if (sum !== 10'd40 || sum_vld !== 1'b1 || ovr_err !== 1'b0) begin
         n_fail++;
         $display("FAIL dl_load: sum=%0d vld=%b ovr=%b, required 40/1/0", sum, sum_vld, ovr_err);
      end
      step(0, 0, 0, 1);
   endtask

   task automatic test_overrun();
      for (int i = 1; i <= 4; i++) step(1, i, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 10, 0, 0);
      n_checks++;
      if (sum !== 10'd10 || sum_vld !== 1'b1 || ovr_err !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_drop: sum=%0d vld=%b ovr=%b, required 10/1/1", sum, sum_vld, ovr_err);
      end
      step(0, 0, 0, 0);
      n_checks++;
      if (sum !== 10'd10 || sum_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_stable: sum=%0d vld=%b, required 10/1", sum, sum_vld);
      end
      step(0, 0, 0, 1);
      n_checks++;
      if (sum_vld !== 1'b0 || ovr_err !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_drain: vld=%b ovr=%b, required 0/1", sum_vld, ovr_err);
      end
   endtask

   task automatic test_abort();
      step(1, 50, 0, 1);
      step(1, 60, 0, 1);
      step(1, 70, 1, 1);
      n_checks++;
      if (busy !== 1'b0 || ovr_err !== 1'b0 || sum_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL abort: busy=%b ovr=%b vld=%b, required 0/0/0", busy, ovr_err, sum_vld);
      end
      for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
      n_checks++;
      if (sum !== 10'd4 || sum_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_next: sum=%0d vld=%b, required 4/1", sum, sum_vld);
      end
      step(0, 0, 0, 1);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) step(1, 5, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 7, 0, 0);
      n_checks++;
      if (sum !== 10'd20 || sum_vld !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre: sum=%0d vld=%b busy=%b, required 20/1/1", sum, sum_vld, busy);
      end
      #2 rst_n = 0;
      #1;
      model_reset();
      n_checks++;
      if ({sum, sum_vld, busy, ovr_err} !== '0) begin
         n_fail++;
         $display("FAIL rst_async: sum=%0d vld=%b busy=%b ovr=%b, required all 0", sum, sum_vld, busy, ovr_err);
      end
      @(negedge clk); rst_n = 1;
      for (int i = 0; i < 4; i++) step(1, 2, 0, 1);
      n_checks++;
      if (sum !== 10'd8 || sum_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_after: sum=%0d vld=%b, required 8/1", sum, sum_vld);
      end
      step(0, 0, 0, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 7), $urandom_range(0, 255),
              ($urandom_range(0, 19) == 0), $urandom_range(0, 1));
         n_checks++;
         if (sum !== m_sum[ACC_W-1:0] || sum_vld !== m_vld || ovr_err !== m_ovr
             || busy !== (grp.size() != 0)) begin
            n_fail++;
            $display("FAIL random cycle %0d: sum=%0d vld=%b ovr=%b busy=%b, required %0d/%b/%b/%b",
                     i, sum, sum_vld, ovr_err, busy, m_sum, m_vld, m_ovr, (grp.size() != 0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_drain_load();
      test_overrun();
      test_abort();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
